// File: rtl/shift_quant_pkg.sv
// Shared shift-quantizer definitions: default widths, the zero-coefficient code
// and the single-lane term rule used by both RTL and golden models.
package shift_quant_pkg;

    localparam int FRAC_BITS  = 8;
    localparam int SHW        = 6;
    localparam int SHIFT_ZERO = FRAC_BITS;

    typedef logic [SHW-1:0] shift_t;

    // Codes at or above the fraction width encode a zero coefficient.
    function automatic logic signed [31:0] shift_term(
        input logic signed [31:0] p,
        input int unsigned        s,
        input int unsigned        frac = FRAC_BITS
    );
        if (s >= frac) begin
            return '0;
        end
        return p >>> s;
    endfunction

endpackage

// File: rtl/shift_term_unit.sv
// Combinational single-lane term: sign-extended p >>> s, or zero for the
// zero-coefficient codes.
module shift_term_unit
    import shift_quant_pkg::*;
#(
    parameter int FRAC_BITS = shift_quant_pkg::FRAC_BITS,
    parameter int SHW       = shift_quant_pkg::SHW,
    parameter int DW        = 16,
    parameter int OW        = DW + 2
) (
    input  logic signed [DW-1:0] p,
    input  logic        [SHW-1:0] s,
    output logic signed [OW-1:0] t
);

    always_comb begin
        t = OW'(shift_term(32'(p), 32'(s), FRAC_BITS));
    end

endmodule

// File: rtl/shift_coeff_applier.sv
// Applies four registered right-shift codes to a stream of 2x2 sample quads
// and emits the reconstructed weighted sum through a two-stage valid/ready pipe.
module shift_coeff_applier
    import shift_quant_pkg::*;
#(
    parameter int FRAC_BITS = shift_quant_pkg::FRAC_BITS,
    parameter int SHW       = shift_quant_pkg::SHW,
    parameter int DW        = 16,
    parameter int OW        = DW + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic        [SHW-1:0] s0,
    input  logic        [SHW-1:0] s1,
    input  logic        [SHW-1:0] s2,
    input  logic        [SHW-1:0] s3,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] p00,
    input  logic signed [DW-1:0] p01,
    input  logic signed [DW-1:0] p10,
    input  logic signed [DW-1:0] p11,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic                 busy
);

    logic        [SHW-1:0] shift_bank [4];
    logic signed [DW-1:0]  samp_p0    [4];
    logic signed [OW-1:0]  term_p0    [4];
    logic signed [OW-1:0]  term_p1    [4];
    logic signed [OW-1:0]  sum_p1;
    logic signed [OW-1:0]  sum_p2;
    logic                  vld_p1;
    logic                  vld_p2;
    logic                  s1_adv;
    logic                  s2_adv;
    logic                  accept;

    assign samp_p0[0] = p00;
    assign samp_p0[1] = p01;
    assign samp_p0[2] = p10;
    assign samp_p0[3] = p11;

    // Shift bank: reset to the zero-coefficient code so every term reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shift_bank[i] <= SHW'(FRAC_BITS);
            end
        end else if (cfg_we) begin
            shift_bank[0] <= s0;
            shift_bank[1] <= s1;
            shift_bank[2] <= s2;
            shift_bank[3] <= s3;
        end
    end

    always_comb begin
        s2_adv   = !vld_p2 || out_ready;
        s1_adv   = vld_p1 && s2_adv;
        in_ready = !rst && (!vld_p1 || s2_adv);
        accept   = in_valid && in_ready;
    end

    // ---- stage 0 -> 1: per-lane terms from the current (pre-write) bank ----
    for (genvar g = 0; g < 4; g++) begin : g_lane
        shift_term_unit #(
            .FRAC_BITS(FRAC_BITS),
            .SHW      (SHW),
            .DW       (DW),
            .OW       (OW)
        ) u_term (
            .p(samp_p0[g]),
            .s(shift_bank[g]),
            .t(term_p0[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                term_p1[i] <= term_p0[i];
            end
        end
    end

    // ---- stage 1 -> 2: four-term sum; OW leaves headroom so no saturation ----
    always_comb begin
        sum_p1 = term_p1[0] + term_p1[1] + term_p1[2] + term_p1[3];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            sum_p2 <= '0;
        end else begin
            if (s2_adv) begin
                vld_p2 <= vld_p1;
            end
            if (s1_adv) begin
                sum_p2 <= sum_p1;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_data  = sum_p2;
    assign busy      = vld_p1 || vld_p2;

endmodule

// File: tb/tb_shift_coeff_applier.sv
// Directed bench for shift_coeff_applier: vector table for the term rule plus
// hand-written stall, same-cycle config and mid-stream reset sequences.
module tb_shift_coeff_applier;

    localparam int DW  = 16;
    localparam int SHW = 6;
    localparam int OW  = DW + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_we;
    logic        [SHW-1:0] s0, s1, s2, s3;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] p00, p01, p10, p11;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    shift_coeff_applier #(
        .FRAC_BITS(8),
        .SHW      (SHW),
        .DW       (DW),
        .OW       (OW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .s0       (s0),
        .s1       (s1),
        .s2       (s2),
        .s3       (s3),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .p00      (p00),
        .p01      (p01),
        .p10      (p10),
        .p11      (p11),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    do_cfg;
        int    s0, s1, s2, s3;
        int    p0, p1, p2, p3;
        int    exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic set_quad(input int a, input int b, input int c, input int d);
        p00 = DW'(a);
        p01 = DW'(b);
        p10 = DW'(c);
        p11 = DW'(d);
    endtask

    task automatic write_cfg(input int a, input int b, input int c, input int d);
        s0 = SHW'(a);
        s1 = SHW'(b);
        s2 = SHW'(c);
        s3 = SHW'(d);
        cfg_we = 1'b1;
        edge_wait();
        cfg_we = 1'b0;
    endtask

    // One quad through an idle pipe with out_ready high; checks 2-edge latency.
    task automatic run_quad(input string name, input int a, input int b,
                            input int c, input int d, input int exp);
        set_quad(a, b, c, d);
        in_valid = 1'b1;
        #1;
        chk({name, ".in_ready"}, int'(in_ready), 1);
        edge_wait();
        in_valid = 1'b0;
        chk({name, ".valid_n1"}, int'(out_valid), 0);
        edge_wait();
        chk({name, ".valid_n2"}, int'(out_valid), 1);
        chk({name, ".data"}, int'(out_data), exp);
        edge_wait();
    endtask

    initial begin
        int exp_q[$];
        int got;
        int first_out;
        int last_out;

        vecs[0] = '{"nocfg",  1'b0, 0, 0, 0, 0,  256, 256, 256, 256, 0};
        vecs[1] = '{"s0123",  1'b1, 0, 1, 2, 3,  256, 256, 256, 256, 480};
        vecs[2] = '{"floor",  1'b1, 1, 1, 1, 1,  -3, -3, -3, -3, -8};
        vecs[3] = '{"zcode",  1'b1, 8, 63, 0, 0, 100, 100, 32767, -32768, -1};
        vecs[4] = '{"maxpos", 1'b1, 0, 0, 0, 0,  32767, 32767, 32767, 32767, 131068};
        vecs[5] = '{"maxneg", 1'b0, 0, 0, 0, 0,  -32768, -32768, -32768, -32768, -131072};
        vecs[6] = '{"s7mix",  1'b1, 7, 7, 7, 7,  255, -1, 128, -129, -1};
        vecs[7] = '{"s0000",  1'b1, 0, 0, 0, 0,  1, -2, 3, -4, -2};

        rst = 1'b1; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        s0 = '0; s1 = '0; s2 = '0; s3 = '0;
        set_quad(0, 0, 0, 0);
        edge_wait();
        edge_wait();
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.in_ready", int'(in_ready), 0);
        chk("rst.out_data", int'(out_data), 0);
        rst = 1'b0;
        edge_wait();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_cfg) begin
                write_cfg(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3);
            end
            run_quad(vecs[i].name, vecs[i].p0, vecs[i].p1, vecs[i].p2,
                     vecs[i].p3, vecs[i].exp);
        end

        // Stall: out_ready low for the first 3 cycles, 4 quads of (v x4), bank all 0.
        got = 0;
        first_out = -1;
        last_out = -1;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c >= 3);
            in_valid  = (exp_q.size() + got < 4);
            set_quad(10 * (exp_q.size() + got + 1), 10 * (exp_q.size() + got + 1),
                     10 * (exp_q.size() + got + 1), 10 * (exp_q.size() + got + 1));
            #1;
            if (c == 2) begin
                chk("stall.in_ready_low", int'(in_ready), 0);
                chk("stall.busy", int'(busy), 1);
            end
            if (out_valid && !out_ready && exp_q.size() > 0) begin
                chk("stall.held", int'(out_data), exp_q[0]);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stall.spurious", 1, 0);
                end else begin
                    chk("stall.order", int'(out_data), exp_q.pop_front());
                    got++;
                    if (first_out < 0) first_out = c;
                    last_out = c;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(40 * (exp_q.size() + got + 1));
            end
            edge_wait();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stall.count", got, 4);
        chk("stall.first_out", first_out, 3);
        chk("stall.back_to_back", last_out - first_out, 3);

        // Same-cycle cfg write: A uses the old bank (0s), B the new one (1s).
        set_quad(64, 64, 64, 64);
        s0 = 6'd1; s1 = 6'd1; s2 = 6'd1; s3 = 6'd1;
        cfg_we = 1'b1;
        in_valid = 1'b1;
        edge_wait();
        cfg_we = 1'b0;
        edge_wait();
        in_valid = 1'b0;
        chk("samecfg.A_valid", int'(out_valid), 1);
        chk("samecfg.A", int'(out_data), 256);
        edge_wait();
        chk("samecfg.B_valid", int'(out_valid), 1);
        chk("samecfg.B", int'(out_data), 128);
        edge_wait();
        chk("samecfg.drained", int'(busy), 0);

        // Reset with two quads in flight and downstream stalled.
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_quad(100, 100, 100, 100);
        edge_wait();
        edge_wait();
        in_valid = 1'b0;
        chk("midrst.busy_before", int'(busy), 1);
        rst = 1'b1;
        edge_wait();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) begin
                chk("midrst.emitted", int'(out_valid), 0);
            end
            edge_wait();
        end
        chk("midrst.busy_after", int'(busy), 0);
        chk("midrst.out_data", int'(out_data), 0);
        run_quad("midrst.bank", 256, 256, 256, 256, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
